// File: rtl/ncl_clocked_sink.sv
// ncl_clocked_sink
//   Clocked consumer at the tail of a single-rail NCL pipeline. It synchronizes
//   the asynchronous pipe output and drives the completion back into the last
//   stage through a small handshake FSM. It also counts accepted DATA tokens,
//   measures the clk period between tokens, and flags a stalled pipeline.
//
// Ports
//   clk_i          clock
//   init_n_i       async active-low reset, shared with the pipeline init
//   pipe_d_i       async data from the last stage (1=DATA, 0=NULL)
//   pipe_comp_o    completion to the last stage (1=DATA taken, 0=NULL taken)
//   stall_i        1 = withhold the DATA acknowledge
//   clr_stats_i    sync clear of token count, period measurement and stuck
//   token_pulse_o  one-cycle pulse per accepted DATA token
//   token_count_o  accepted tokens, wraps modulo 2^CNT_W
//   last_period_o  clk cycles between the last two tokens, saturating
//   period_vld_o   last_period_o holds a real measurement
//   stuck_o        sticky: no input transition for TIMEOUT cycles while waiting
module ncl_clocked_sink #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ACK_DELAY   = 0,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned PER_W       = 12,
   parameter int unsigned TIMEOUT     = 1000
) (
   input  logic             clk_i,
   input  logic             init_n_i,
   input  logic             pipe_d_i,
   output logic             pipe_comp_o,
   input  logic             stall_i,
   input  logic             clr_stats_i,
   output logic             token_pulse_o,
   output logic [CNT_W-1:0] token_count_o,
   output logic [PER_W-1:0] last_period_o,
   output logic             period_vld_o,
   output logic             stuck_o
);

   typedef enum logic [1:0] {WAIT_DATA, HOLD_D, WAIT_NULL, HOLD_N} state_e;

   // The edge that sees the synchronized transition already counts as the
   // first hold cycle, so the hold counter is loaded one short. This keeps
   // the pipe_d -> pipe_comp latency at SYNC_STAGES+1+ACK_DELAY edges.
   localparam logic [7:0]       DLY_LOAD = 8'((ACK_DELAY == 0) ? 0 : ACK_DELAY - 1);
   localparam logic [PER_W-1:0] PER_MAX  = '1;
   localparam logic [PER_W-1:0] TO_VAL   = PER_W'(TIMEOUT);

   // ---------------- synchronizer ----------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ds;

   always_ff @(posedge clk_i or negedge init_n_i) begin
      if (!init_n_i) sync_q <= '0;
      else           sync_q <= {sync_q[SYNC_STAGES-2:0], pipe_d_i};
   end

   assign ds = sync_q[SYNC_STAGES-1];

   // ---------------- handshake FSM ----------------
   state_e     state_q;
   logic [7:0] dly_q;
   logic       comp_q;
   logic       pulse_q;
   logic       accept;

   // With no delay, the HOLD_D decision is folded into the WAIT_DATA edge;
   // otherwise stall only matters once the delay has run out.
   assign accept = !stall_i &&
                   ((state_q == HOLD_D && dly_q == 8'd0) ||
                    (ACK_DELAY == 0 && state_q == WAIT_DATA && ds));

   always_ff @(posedge clk_i or negedge init_n_i) begin
      if (!init_n_i) begin
         state_q <= WAIT_DATA;
         dly_q   <= 8'd0;
         comp_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         pulse_q <= accept;
         unique case (state_q)
            WAIT_DATA: begin
               if (accept) begin
                  state_q <= WAIT_NULL;
                  comp_q  <= 1'b1;
               end else if (ds) begin
                  state_q <= HOLD_D;
                  dly_q   <= DLY_LOAD;
               end
            end
            HOLD_D: begin
               if (dly_q != 8'd0) begin
                  dly_q <= dly_q - 8'd1;
               end else if (accept) begin
                  state_q <= WAIT_NULL;
                  comp_q  <= 1'b1;
               end
            end
            WAIT_NULL: begin
               if (!ds) begin
                  if (ACK_DELAY == 0) begin
                     state_q <= WAIT_DATA;
                     comp_q  <= 1'b0;
                  end else begin
                     state_q <= HOLD_N;
                     dly_q   <= DLY_LOAD;
                  end
               end
            end
            HOLD_N: begin
               if (dly_q != 8'd0) begin
                  dly_q <= dly_q - 8'd1;
               end else begin
                  state_q <= WAIT_DATA;
                  comp_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= WAIT_DATA;
               comp_q  <= 1'b0;
            end
         endcase
      end
   end

   // ---------------- statistics ----------------
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PER_W-1:0] per_q, per_d;
   logic [PER_W-1:0] last_q, last_d;
   logic [PER_W-1:0] idle_q, idle_d;
   logic             vld_q, vld_d;
   logic             seen_q, seen_d;
   logic             stuck_q, stuck_d;
   logic             idle_wait;

   // Waiting with no transition on the synchronized input.
   assign idle_wait = (state_q == WAIT_DATA && !ds) || (state_q == WAIT_NULL && ds);

   always_comb begin
      cnt_d   = cnt_q;
      per_d   = (per_q == PER_MAX) ? per_q : per_q + 1'b1;
      last_d  = last_q;
      vld_d   = vld_q;
      seen_d  = seen_q;
      stuck_d = stuck_q | (idle_q == TO_VAL);
      idle_d  = idle_wait ? ((idle_q == TO_VAL) ? idle_q : idle_q + 1'b1) : '0;

      // Clear first so a token in the same cycle is counted afresh.
      // The idle counter restarts too, giving a full new timeout window.
      if (clr_stats_i) begin
         cnt_d   = '0;
         last_d  = '0;
         vld_d   = 1'b0;
         seen_d  = 1'b0;
         stuck_d = 1'b0;
         idle_d  = '0;
      end

      if (accept) begin
         cnt_d  = cnt_d + 1'b1;
         if (seen_d) begin
            last_d = per_q;
            vld_d  = 1'b1;
         end
         seen_d = 1'b1;
         per_d  = {{(PER_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_i or negedge init_n_i) begin
      if (!init_n_i) begin
         cnt_q   <= '0;
         per_q   <= '0;
         last_q  <= '0;
         idle_q  <= '0;
         vld_q   <= 1'b0;
         seen_q  <= 1'b0;
         stuck_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         last_q  <= last_d;
         idle_q  <= idle_d;
         vld_q   <= vld_d;
         seen_q  <= seen_d;
         stuck_q <= stuck_d;
      end
   end

   assign pipe_comp_o   = comp_q;
   assign token_pulse_o = pulse_q;
   assign token_count_o = cnt_q;
   assign last_period_o = last_q;
   assign period_vld_o  = vld_q;
   assign stuck_o       = stuck_q;

endmodule

// File: tb/tb_ncl_clocked_sink.sv
// Bench for ncl_clocked_sink. Instance a: ACK_DELAY=0, TIMEOUT=100, default
// widths, driven by a randomized handshaking source and directed steps.
// Instance b: ACK_DELAY=4, CNT_W=4, PER_W=4 for latency, wrap and saturation.
module tb_ncl_clocked_sink;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic a_rst_n, a_pd, a_stall, a_clr, a_comp, a_pulse, a_vld, a_stuck;
   logic [15:0] a_cnt;
   logic [11:0] a_per;
   logic b_rst_n, b_pd, b_stall, b_clr, b_comp, b_pulse, b_vld, b_stuck;
   logic [3:0] b_cnt, b_per;

   ncl_clocked_sink #(.SYNC_STAGES(2), .ACK_DELAY(0), .CNT_W(16), .PER_W(12), .TIMEOUT(100)) dut_a (
      .clk_i(clk), .init_n_i(a_rst_n), .pipe_d_i(a_pd), .pipe_comp_o(a_comp),
      .stall_i(a_stall), .clr_stats_i(a_clr), .token_pulse_o(a_pulse),
      .token_count_o(a_cnt), .last_period_o(a_per), .period_vld_o(a_vld), .stuck_o(a_stuck));

   ncl_clocked_sink #(.SYNC_STAGES(2), .ACK_DELAY(4), .CNT_W(4), .PER_W(4), .TIMEOUT(15)) dut_b (
      .clk_i(clk), .init_n_i(b_rst_n), .pipe_d_i(b_pd), .pipe_comp_o(b_comp),
      .stall_i(b_stall), .clr_stats_i(b_clr), .token_pulse_o(b_pulse),
      .token_count_o(b_cnt), .last_period_o(b_per), .period_vld_o(b_vld), .stuck_o(b_stuck));

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for instance a's completion to reach v, then check it.
   task automatic wait_a(input logic v, input string tag);
      for (int k = 0; k < 40 && a_comp !== v; k++) @(negedge clk);
      chk(tag, a_comp, v);
   endtask

   // Reference state for the randomized run: pipe_d level seen at each edge.
   int  h [0:511];
   int  e, wt, m_cnt, m_last, m_per, k;
   bit  m_have, m_vld, tok, bad;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      a_rst_n = 0; a_pd = 0; a_stall = 0; a_clr = 0;
      b_rst_n = 0; b_pd = 0; b_stall = 0; b_clr = 0;
      repeat (3) @(negedge clk);
      chk("rst_comp", a_comp, 0);
      chk("rst_pulse", a_pulse, 0);
      chk("rst_cnt", a_cnt, 0);
      chk("rst_per", a_per, 0);
      chk("rst_vld", a_vld, 0);
      chk("rst_stuck", a_stuck, 0);
      chk("rst_b_comp", b_comp, 0);
      a_rst_n = 1; b_rst_n = 1;

      // ---- T1: random handshaking source; comp follows pipe_d 3 edges late ----
      for (int i = 0; i < 512; i++) h[i] = 0;
      e = 0; wt = 0; m_cnt = 0; m_last = 0; m_per = 0; m_have = 0; m_vld = 0; bad = 0;
      for (int i = 0; i < 260; i++) begin
         @(posedge clk);
         e++;
         h[e] = int'(a_pd);
         @(negedge clk);
         tok = (e >= 3 && h[e-2] == 1 && h[e-3] == 0);
         if (tok) begin
            m_cnt++;
            if (m_have) begin
               m_per = (e - m_last > 4095) ? 4095 : e - m_last;
               m_vld = 1;
            end
            m_have = 1;
            m_last = e;
         end
         chk("t1_comp", a_comp, (e >= 2) ? h[e-2] : 0);
         chk("t1_pulse", a_pulse, tok);
         chk("t1_cnt", a_cnt, m_cnt);
         chk("t1_per", a_per, m_per);
         chk("t1_vld", a_vld, m_vld);
         bad |= a_stuck;
         if (a_comp == a_pd) begin
            if (i >= 200) a_pd = 0;
            else if (wt == 0) begin
               a_pd = ~a_pd;
               wt = $urandom_range(0, 3);
            end else wt--;
         end
      end
      chk("t1_never_stuck", bad, 0);
      chk("t1_some_tokens", (m_cnt > 10), 1);

      // ---- T2: stall holds the DATA acknowledge without setting stuck ----
      a_stall = 1; a_pd = 1; bad = 0;
      repeat (150) begin
         @(negedge clk);
         bad |= a_comp | a_pulse | a_stuck;
      end
      chk("t2_stall_hold", bad, 0);
      chk("t2_cnt_hold", a_cnt, m_cnt);
      a_stall = 0;
      @(negedge clk);
      chk("t2_comp", a_comp, 1);
      chk("t2_pulse", a_pulse, 1);
      m_cnt++;
      chk("t2_cnt", a_cnt, m_cnt);
      a_pd = 0;
      wait_a(0, "t2_null_ack");

      // ---- T5: idle in WAIT_DATA -> stuck; clr_stats clears ----
      repeat (95) @(negedge clk);
      chk("t5_not_yet", a_stuck, 0);
      repeat (10) @(negedge clk);
      chk("t5_stuck", a_stuck, 1);
      a_clr = 1;
      @(negedge clk);
      a_clr = 0;
      chk("t5_clr_stuck", a_stuck, 0);
      chk("t5_clr_cnt", a_cnt, 0);
      chk("t5_clr_vld", a_vld, 0);
      chk("t5_clr_per", a_per, 0);
      repeat (5) @(negedge clk);
      chk("t5_stays_clr", a_stuck, 0);
      chk("t5_comp_kept", a_comp, 0);

      // ---- clr_stats coincident with a token ----
      a_pd = 1;
      wait_a(1, "tc_first_ack");
      chk("tc_first_cnt", a_cnt, 1);
      chk("tc_first_vld", a_vld, 0);
      a_pd = 0;
      wait_a(0, "tc_null_ack");
      a_pd = 1;
      @(negedge clk);
      @(negedge clk);
      a_clr = 1;
      @(negedge clk);
      a_clr = 0;
      chk("tc_pulse", a_pulse, 1);
      chk("tc_cnt", a_cnt, 1);
      chk("tc_vld", a_vld, 0);
      chk("tc_comp", a_comp, 1);

      // ---- T6: reset during WAIT_NULL, DATA still present afterwards ----
      #2 a_rst_n = 0;
      #1;
      chk("t6_comp_async", a_comp, 0);
      chk("t6_cnt_async", a_cnt, 0);
      @(negedge clk);
      a_rst_n = 1;
      wait_a(1, "t6_reack");
      chk("t6_cnt", a_cnt, 1);
      chk("t6_vld", a_vld, 0);

      // ---- T3/T4: ACK_DELAY=4, toggle as soon as comp follows ----
      for (int t = 1; t <= 17; t++) begin
         b_pd = 1;
         k = 0;
         do begin @(negedge clk); k++; end while (b_comp !== 1 && k < 30);
         chk("t3_rise_lat", k, 7);
         if (t == 1) chk("t3_first_vld", b_vld, 0);
         if (t == 2) begin
            chk("t3_period", b_per, 14);
            chk("t3_vld", b_vld, 1);
         end
         b_pd = 0;
         k = 0;
         do begin @(negedge clk); k++; end while (b_comp !== 0 && k < 30);
         chk("t3_fall_lat", k, 7);
      end
      chk("t4_wrap_cnt", b_cnt, 17 % 16);
      chk("t4_period_14", b_per, 14);
      repeat (20) @(negedge clk);
      b_pd = 1;
      k = 0;
      do begin @(negedge clk); k++; end while (b_comp !== 1 && k < 30);
      chk("t4_gap_lat", k, 7);
      chk("t4_sat_period", b_per, 15);
      chk("t4_cnt", b_cnt, 2);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
